// File: rtl/uart_mmio_fifo_ctrl_if.sv
// CPU load/store port into the UART register window.
// master drives the access, slave answers with hit/read_data.
interface uart_mmio_fifo_ctrl_if;
  logic [31:0] addr;
  logic        write_en;
  logic        read_en;
  logic [7:0]  write_data;
  logic        hit;
  logic [31:0] read_data;

  modport master (
    output addr, write_en, read_en, write_data,
    input  hit, read_data
  );

  modport slave (
    input  addr, write_en, read_en, write_data,
    output hit, read_data
  );
endinterface

// File: rtl/uart_mmio_fifo_ctrl.sv
// MMIO UART controller: TX/RX byte FIFOs behind a 5-register window.
// Sticky overflow/underflow flags, cleared by writing ones to ERR.
module uart_mmio_fifo_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_mmio_fifo_ctrl_if.slave  bus,
  output logic [7:0]            data_in,
  output logic                  data_in_valid,
  input  logic                  data_in_ready,
  input  logic [7:0]            data_out,
  input  logic                  data_out_valid,
  output logic                  data_out_ready
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [7:0] TXD = 8'(TX_DEPTH);
  localparam logic [7:0] RXD = 8'(RX_DEPTH);
  localparam logic [TAW-1:0] TX_LAST = TAW'(TX_DEPTH - 1);
  localparam logic [RAW-1:0] RX_LAST = RAW'(RX_DEPTH - 1);

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic           tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

  logic [31:0] off;
  logic        in_win;
  logic        sel_txs, sel_rxs, sel_txd, sel_rxd, sel_err;
  logic        tx_full, tx_push, tx_pop, tx_ovf_set;
  logic        rx_empty, rx_push, rx_pop, rx_unf_set;
  logic [7:0]  rx_head;

  always_comb begin
    off     = bus.addr - BASE_ADDR;
    in_win  = (off[31:5] == 27'd0) && (off[1:0] == 2'd0);
    sel_txs = in_win && (off[4:2] == 3'd0);
    sel_rxs = in_win && (off[4:2] == 3'd1);
    sel_txd = in_win && (off[4:2] == 3'd2);
    sel_rxd = in_win && (off[4:2] == 3'd3);
    sel_err = in_win && (off[4:2] == 3'd4);
    bus.hit = (bus.read_en | bus.write_en)
            & (sel_txs | sel_rxs | sel_txd | sel_rxd | sel_err);

    tx_full    = (tx_cnt_q == TXD);
    tx_push    = bus.write_en & sel_txd & ~tx_full;
    tx_ovf_set = bus.write_en & sel_txd & tx_full;
    tx_pop     = data_in_valid & data_in_ready;

    rx_empty   = (rx_cnt_q == 8'd0);
    rx_push    = data_out_valid & data_out_ready;
    rx_pop     = bus.read_en & sel_rxd & ~rx_empty;
    rx_unf_set = bus.read_en & sel_rxd & rx_empty;
    rx_head    = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
  end

  // Outputs gated by count so reset forces them low immediately
  always_comb begin
    data_in_valid  = (tx_cnt_q != 8'd0);
    data_in        = data_in_valid ? tx_mem_q[tx_rd_q] : 8'h00;
    data_out_ready = rst_n & (rx_cnt_q < RXD);
  end

  always_comb begin
    bus.read_data = 32'd0;
    if (bus.read_en) begin
      unique case (1'b1)
        sel_txs: bus.read_data = {16'd0, tx_cnt_q, 7'd0, ~tx_full};
        sel_rxs: bus.read_data = {16'd0, rx_cnt_q, 7'd0, ~rx_empty};
        sel_rxd: bus.read_data = {24'd0, rx_head};
        sel_err: bus.read_data = {30'd0, rx_unf_q, tx_ovf_q};
        default: bus.read_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    if (tx_push) tx_wr_d = (tx_wr_q == TX_LAST) ? '0 : tx_wr_q + 1'b1;
    if (tx_pop)  tx_rd_d = (tx_rd_q == TX_LAST) ? '0 : tx_rd_q + 1'b1;
    if (rx_push) rx_wr_d = (rx_wr_q == RX_LAST) ? '0 : rx_wr_q + 1'b1;
    if (rx_pop)  rx_rd_d = (rx_rd_q == RX_LAST) ? '0 : rx_rd_q + 1'b1;

    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 8'd1;
      2'b01:   tx_cnt_d = tx_cnt_q - 8'd1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 8'd1;
      2'b01:   rx_cnt_d = rx_cnt_q - 8'd1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    // Clear first so a same-cycle set wins
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (bus.write_en && sel_err) begin
      if (bus.write_data[0]) tx_ovf_d = 1'b0;
      if (bus.write_data[1]) rx_unf_d = 1'b0;
    end
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_unf_set) rx_unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
    end else begin
      if (tx_push) tx_mem_q[tx_wr_q] <= bus.write_data;
      if (rx_push) rx_mem_q[rx_wr_q] <= data_out;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo_ctrl.sv
// Directed bench for uart_mmio_fifo_ctrl.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_uart_mmio_fifo_ctrl;
  localparam logic [31:0] B = 32'h8000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       data_out_valid = 1'b0;
  logic       data_out_ready;
  int         tests = 0;
  int         fails = 0;

  uart_mmio_fifo_ctrl_if bus ();

  uart_mmio_fifo_ctrl #(
    .BASE_ADDR (B),
    .TX_DEPTH  (8),
    .RX_DEPTH  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.write_data = d;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
    bus.addr = a;
    bus.read_en = 1'b1;
    #1;
    chk({tag, "_hit"}, {31'd0, bus.hit}, 32'd1);
    chk(tag, bus.read_data, exp);
    @(negedge clk);
    bus.read_en = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    data_out = d;
    data_out_valid = 1'b1;
    #1;
    chk("rx_rdy", {31'd0, data_out_ready}, 32'd1);
    @(negedge clk);
    data_out_valid = 1'b0;
  endtask

  initial begin
    bus.addr = 32'd0;
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    bus.write_data = 8'h00;

    // 1: reset state
    #12;
    chk("rst_dvalid", {31'd0, data_in_valid}, 32'd0);
    chk("rst_oready", {31'd0, data_out_ready}, 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load("txstat0", B + 32'h00, 32'h0000_0001);
    load("rxstat0", B + 32'h04, 32'h0000_0000);
    chk("dvalid0", {31'd0, data_in_valid}, 32'd0);
    chk("oready0", {31'd0, data_out_ready}, 32'd1);

    // 2: three stores then drain
    store(B + 32'h08, 8'h41);
    store(B + 32'h08, 8'h42);
    store(B + 32'h08, 8'h43);
    load("txstat3", B + 32'h00, 32'h0000_0301);
    chk("head41", {24'd0, data_in}, 32'h41);
    data_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("tx_out", {24'd0, data_in}, 32'h41 + i);
      @(negedge clk);
    end
    data_in_ready = 1'b0;
    #1;
    chk("tx_drained", {31'd0, data_in_valid}, 32'd0);
    @(negedge clk);

    // 3: overflow on 9th store
    for (int i = 0; i < 9; i++) store(B + 32'h08, 8'(8'h50 + i));
    load("txstat8", B + 32'h00, 32'h0000_0800);
    load("err_ovf", B + 32'h10, 32'h0000_0001);
    store(B + 32'h10, 8'h01);
    load("err_clr", B + 32'h10, 32'h0000_0000);
    data_in_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tx_full_out", {24'd0, data_in}, 32'h50 + i);
      @(negedge clk);
    end
    data_in_ready = 1'b0;
    #1;
    chk("no_9th", {31'd0, data_in_valid}, 32'd0);
    @(negedge clk);

    // 4: fill RX, drain, underflow
    for (int i = 0; i < 8; i++) rx_push(8'(8'hC0 + i));
    #1;
    chk("rx_full_rdy", {31'd0, data_out_ready}, 32'd0);
    @(negedge clk);
    load("rxstat8", B + 32'h04, 32'h0000_0801);
    for (int i = 0; i < 8; i++) load("rxdata", B + 32'h0C, 32'hC0 + i);
    load("rx_empty", B + 32'h0C, 32'h0000_0000);
    load("err_unf", B + 32'h10, 32'h0000_0002);
    store(B + 32'h10, 8'h02);
    load("err_clr2", B + 32'h10, 32'h0000_0000);

    // 5: simultaneous RX push and pop, then misses
    rx_push(8'hA0);
    rx_push(8'hA1);
    rx_push(8'hA2);
    bus.addr = B + 32'h0C;
    bus.read_en = 1'b1;
    data_out = 8'hA3;
    data_out_valid = 1'b1;
    #1;
    chk("pp_head", bus.read_data, 32'h0000_00A0);
    @(negedge clk);
    bus.read_en = 1'b0;
    data_out_valid = 1'b0;
    load("rxstat3", B + 32'h04, 32'h0000_0301);
    load("pp_a1", B + 32'h0C, 32'h0000_00A1);
    load("pp_a2", B + 32'h0C, 32'h0000_00A2);
    load("pp_a3", B + 32'h0C, 32'h0000_00A3);
    bus.addr = B + 32'h07;
    bus.read_en = 1'b1;
    #1;
    chk("miss07_hit", {31'd0, bus.hit}, 32'd0);
    chk("miss07_rd", bus.read_data, 32'd0);
    bus.addr = B + 32'h14;
    #1;
    chk("miss14_hit", {31'd0, bus.hit}, 32'd0);
    chk("miss14_rd", bus.read_data, 32'd0);
    @(negedge clk);
    bus.read_en = 1'b0;
    load("miss_noerr", B + 32'h10, 32'h0000_0000);

    // 6: reset mid-transfer
    for (int i = 0; i < 4; i++) store(B + 32'h08, 8'(8'h10 + i));
    load("txstat4", B + 32'h00, 32'h0000_0401);
    data_in_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dv", {31'd0, data_in_valid}, 32'd0);
    chk("rst_mid_di", {24'd0, data_in}, 32'd0);
    chk("rst_mid_or", {31'd0, data_out_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    data_in_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_or", {31'd0, data_out_ready}, 32'd1);
    @(negedge clk);
    load("txstat_rst", B + 32'h00, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
